systolic_tile_ctrl: RTL and testbench
=====================================

// Module: systolic_tile_ctrl
// PURPOSE
//  Multi-tile sequencer for the ROWSxCOLS systolic MAC array; successor to the single-pass 4-state controller.
//  Runs num_tiles back-to-back tiles, each LOAD_X -> MAC (runtime k_len) -> DRAIN (skew flush) -> STORE.
//  Adds stall/abort handling, config checking, per-phase indices and a done pulse for the host/DMA side.
// PARAMETERS
//  ROWS    4   array rows; LOAD_X length in cycles (>=2)
//  COLS    4   array cols; STORE length in cycles (>=2)
//  K_MAX   16  max inner dimension; KW = $clog2(K_MAX+1)
//  TILE_W  8   width of num_tiles / tile_idx
// PORTS
//  clk           in   1                  clock, rising edge
//  rst_n         in   1                  async active-low reset
//  start         in   1                  launch job; sampled only in IDLE
//  abort         in   1                  sync abort, any state
//  stall         in   1                  freeze sequencing (LOAD_X/MAC/DRAIN/STORE)
//  k_len         in   KW                 inner dimension, latched on start
//  num_tiles     in   TILE_W             tile count, latched on start
//  global_state  out  3                  0 IDLE,1 LOAD_X,2 MAC,3 DRAIN,4 STORE,5 DONE
//  busy          out  1                  state != IDLE
//  load_en       out  1                  LOAD_X && !stall
//  mac_en        out  1                  MAC && !stall
//  acc_clr       out  1                  first MAC cycle of each tile && !stall
//  store_en      out  1                  STORE && !stall
//  load_idx      out  $clog2(ROWS)       row index in LOAD_X
//  k_idx         out  $clog2(K_MAX)      MAC step index
//  store_idx     out  $clog2(COLS)       col index in STORE
//  tile_idx      out  TILE_W             current tile
//  done          out  1                  1-cycle pulse in DONE
//  cfg_err       out  1                  1-cycle pulse on rejected start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, indices, latched cfg = 0. Async assert, deassert into IDLE.
//  IDLE: start && 1<=k_len<=K_MAX && num_tiles!=0 -> latch cfg, tile_idx=0, go LOAD_X next cycle.
//        start with bad cfg -> cfg_err=1 next cycle, remain IDLE. start ignored in every other state.
//  LOAD_X: ROWS active cycles, load_idx 0..ROWS-1; at ROWS-1 -> MAC.
//  MAC: k_len active cycles, k_idx 0..k_len-1, acc_clr with k_idx==0; at k_len-1 -> DRAIN.
//  DRAIN: ROWS+COLS-2 cycles, no enables (wavefront flush); internal counter not exported.
//  STORE: COLS active cycles, store_idx 0..COLS-1; at COLS-1: last tile -> DONE, else tile_idx+1 -> LOAD_X.
//  DONE: exactly one cycle, done=1, busy=1 -> IDLE. New start accepted in the following IDLE cycle.
//  Tile latency, no stall: ROWS+k_len+ROWS+COLS-2+COLS cycles; job = num_tiles*tile + 1 (DONE).
//  stall: counters, indices, state frozen; enables forced low; exits on first unstalled final count.
//  abort (priority over stall/start): -> IDLE next cycle, indices/tile_idx cleared, no done pulse.
//  Single internal phase counter reused per state, cleared on every state transition.
//  Index outputs hold 0 outside their own state. k_len/num_tiles changes while busy have no effect.
// TESTING (ROWS=COLS=4, K_MAX=16)
//  T1 start, k_len=4, num_tiles=1 -> LOAD 4, MAC 4, DRAIN 6, STORE 4 cycles; done in 19th cycle after start edge.
//  T2 k_len=2, num_tiles=3 -> tile_idx 0,1,2; three acc_clr pulses; 48 active cycles then 1-cycle done.
//  T3 k_len=8, stall 3 cycles at k_idx=3 -> k_idx holds 3, mac_en low, done 3 cycles later than unstalled.
//  T4 start with k_len=0, k_len=17, num_tiles=0 -> one cfg_err pulse each, busy stays 0, no done.
//  T5 abort in STORE of tile 1 of 3 -> IDLE next cycle, tile_idx=0, no done; rst_n low mid-MAC -> outputs 0 at once.
//  T6 start held high continuously -> ignored while busy; new job launches 1 cycle after DONE, back-to-back.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: multi-tile sequencer for a ROWSxCOLS systolic MAC array.
// Each tile runs LOAD_X -> MAC (k_len steps) -> DRAIN (wavefront flush) -> STORE,
// then the next tile or a single DONE cycle. Supports stall, abort and config checking.
module systolic_tile_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 16,
  parameter int TILE_W = 8,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int LW    = $clog2(ROWS),
  localparam int KIW   = $clog2(K_MAX),
  localparam int SW    = $clog2(COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_stall,
  input  logic [KW-1:0]     i_k_len,
  input  logic [TILE_W-1:0] i_num_tiles,
  output logic [2:0]        o_global_state,
  output logic              o_busy,
  output logic              o_load_en,
  output logic              o_mac_en,
  output logic              o_acc_clr,
  output logic              o_store_en,
  output logic [LW-1:0]     o_load_idx,
  output logic [KIW-1:0]    o_k_idx,
  output logic [SW-1:0]     o_store_idx,
  output logic [TILE_W-1:0] o_tile_idx,
  output logic              o_done,
  output logic              o_cfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Skew flush: the last partial sum needs ROWS+COLS-2 cycles to leave the array.
  localparam int DRAIN_LEN = ROWS + COLS - 2;
  localparam int PMAX01    = (ROWS > K_MAX) ? ROWS : K_MAX;
  localparam int PMAX012   = (PMAX01 > DRAIN_LEN) ? PMAX01 : DRAIN_LEN;
  localparam int PMAX      = (PMAX012 > COLS) ? PMAX012 : COLS;
  localparam int CW        = $clog2(PMAX + 1);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_phase;    // shared per-state counter, cleared on every transition
  logic [KW-1:0]     r_k_len;
  logic [TILE_W-1:0] r_num_tiles;
  logic [TILE_W-1:0] r_tile;
  logic              r_cfg_err;

  logic              w_cfg_ok;
  logic              w_last;
  logic              w_last_tile;

  assign w_cfg_ok    = (i_k_len != '0) && (i_k_len <= KW'(K_MAX)) && (i_num_tiles != '0);
  assign w_last_tile = (r_tile == r_num_tiles - TILE_W'(1));

  // Final count of the current phase; DRAIN/STORE/LOAD lengths are fixed, MAC is runtime.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_LOAD:  w_last = (r_phase == CW'(ROWS - 1));
      S_MAC:   w_last = (r_phase == CW'(r_k_len) - CW'(1));
      S_DRAIN: w_last = (r_phase == CW'(DRAIN_LEN - 1));
      S_STORE: w_last = (r_phase == CW'(COLS - 1));
      default: w_last = 1'b0;
    endcase
  end

  // Sequencer: abort wins over everything; stall freezes the four working phases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_k_len     <= '0;
      r_num_tiles <= '0;
      r_tile      <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_phase <= '0;
        r_tile  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_cfg_ok) begin
                r_k_len     <= i_k_len;
                r_num_tiles <= i_num_tiles;
                r_tile      <= '0;
                r_phase     <= '0;
                r_state     <= S_LOAD;
              end else begin
                r_cfg_err   <= 1'b1;
              end
            end
          end
          S_LOAD, S_MAC, S_DRAIN, S_STORE: begin
            if (!i_stall) begin
              if (w_last) begin
                r_phase <= '0;
                case (r_state)
                  S_LOAD:  r_state <= S_MAC;
                  S_MAC:   r_state <= S_DRAIN;
                  S_DRAIN: r_state <= S_STORE;
                  default: begin
                    if (w_last_tile) begin
                      r_state <= S_DONE;
                    end else begin
                      r_tile  <= r_tile + TILE_W'(1);
                      r_state <= S_LOAD;
                    end
                  end
                endcase
              end else begin
                r_phase <= r_phase + CW'(1);
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_tile  <= '0;
          end
          default: begin
            r_state <= S_IDLE;
            r_phase <= '0;
          end
        endcase
      end
    end
  end

  // Enables and indices decode straight from state/phase; indices read 0 outside their phase.
  always_comb begin
    o_global_state = r_state;
    o_busy         = (r_state != S_IDLE);
    o_load_en      = (r_state == S_LOAD)  && !i_stall;
    o_mac_en       = (r_state == S_MAC)   && !i_stall;
    o_acc_clr      = (r_state == S_MAC)   && (r_phase == '0) && !i_stall;
    o_store_en     = (r_state == S_STORE) && !i_stall;
    o_load_idx     = (r_state == S_LOAD)  ? LW'(r_phase)  : '0;
    o_k_idx        = (r_state == S_MAC)   ? KIW'(r_phase) : '0;
    o_store_idx    = (r_state == S_STORE) ? SW'(r_phase)  : '0;
    o_tile_idx     = r_tile;
    o_done         = (r_state == S_DONE);
    o_cfg_err      = r_cfg_err;
  end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a schedule-queue model of the job.
module tb_systolic_tile_ctrl;
  localparam int ROWS = 4, COLS = 4, K_MAX = 16, TILE_W = 8;
  localparam int KW = 5, DL = ROWS + COLS - 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [TILE_W-1:0] num_tiles = '0;

  logic [2:0]        o_global_state;
  logic              o_busy, o_load_en, o_mac_en, o_acc_clr, o_store_en, o_done, o_cfg_err;
  logic [1:0]        o_load_idx, o_store_idx;
  logic [3:0]        o_k_idx;
  logic [TILE_W-1:0] o_tile_idx;

  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .TILE_W(TILE_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_stall(stall),
    .i_k_len(k_len), .i_num_tiles(num_tiles),
    .o_global_state(o_global_state), .o_busy(o_busy), .o_load_en(o_load_en),
    .o_mac_en(o_mac_en), .o_acc_clr(o_acc_clr), .o_store_en(o_store_en),
    .o_load_idx(o_load_idx), .o_k_idx(o_k_idx), .o_store_idx(o_store_idx),
    .o_tile_idx(o_tile_idx), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  // Model: a job is a queue of the beats it must produce (phase, index, tile).
  // Empty queue means idle. A stalled working beat is not consumed.
  typedef struct { int st; int idx; int tile; } ent_t;
  ent_t q[$];
  bit   m_cfgerr = 0;
  int   checks = 0, errors = 0;
  logic obs_done, obs_acc, obs_busy, obs_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int st, input int idx, input int tile);
    ent_t e;
    e.st = st; e.idx = idx; e.tile = tile;
    q.push_back(e);
  endtask

  task automatic build_job(input int k, input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < ROWS; i++) push(1, i, t);
      for (int i = 0; i < k; i++)    push(2, i, t);
      for (int i = 0; i < DL; i++)   push(3, 0, t);
      for (int i = 0; i < COLS; i++) push(4, i, t);
    end
    push(5, 0, n - 1);
  endtask

  task automatic check_all();
    ent_t e;
    e.st = 0; e.idx = 0; e.tile = 0;
    if (q.size() != 0) e = q[0];
    chk("state",     o_global_state, e.st);
    chk("busy",      o_busy,      e.st != 0);
    chk("load_en",   o_load_en,   e.st == 1 && !stall);
    chk("mac_en",    o_mac_en,    e.st == 2 && !stall);
    chk("acc_clr",   o_acc_clr,   e.st == 2 && e.idx == 0 && !stall);
    chk("store_en",  o_store_en,  e.st == 4 && !stall);
    chk("load_idx",  o_load_idx,  e.st == 1 ? e.idx : 0);
    chk("k_idx",     o_k_idx,     e.st == 2 ? e.idx : 0);
    chk("store_idx", o_store_idx, e.st == 4 ? e.idx : 0);
    chk("tile_idx",  o_tile_idx,  e.tile);
    chk("done",      o_done,      e.st == 5);
    chk("cfg_err",   o_cfg_err,   m_cfgerr);
  endtask

  // Advance the model by one clock using the inputs that were sampled at that edge.
  task automatic model_step();
    bit ce;
    ce = 0;
    if (abort) q.delete();
    else if (q.size() == 0) begin
      if (start) begin
        if (k_len >= 1 && k_len <= K_MAX && num_tiles != 0) build_job(int'(k_len), int'(num_tiles));
        else ce = 1;
      end
    end else if (q[0].st == 5 || !stall) void'(q.pop_front());
    m_cfgerr = ce;
  endtask

  // One cycle: drive at negedge, check shortly after, clock, update model.
  task automatic cyc(input logic s, input logic a, input logic l);
    start = s; abort = a; stall = l;
    #1;
    check_all();
    obs_done = o_done; obs_acc = o_acc_clr; obs_busy = o_busy; obs_cfg = o_cfg_err;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Launch a job and run to the done pulse, optionally stalling in MAC at a given k_idx.
  task automatic run_job(input int kl, input int nt, input int stall_k, input int stall_n,
                         output int lat, output int accs, output int act);
    int   stalled;
    logic l;
    stalled = 0; lat = 0; accs = 0; act = 0;
    k_len = KW'(kl); num_tiles = TILE_W'(nt);
    cyc(1, 0, 0);
    obs_done = 0;
    for (int c = 0; c < 2000 && !obs_done; c++) begin
      l = (stall_k >= 0 && o_global_state == 3'd2 && int'(o_k_idx) == stall_k && stalled < stall_n);
      if (l) stalled++;
      lat++;
      cyc(0, 0, l);
      if (obs_acc) accs++;
      if (obs_busy && !obs_done) act++;
    end
    if (!obs_done) chk("job_timeout", 0, 1);
  endtask

  initial begin
    int lat, accs, act, cnt;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", o_global_state, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tile", o_tile_idx, 0);
    chk("rst_cfg_err", o_cfg_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // T1: single tile, k_len=4 -> done in 19th cycle after the start edge
    run_job(4, 1, -1, 0, lat, accs, act);
    chk("t1_latency", lat, 19);
    chk("t1_accs", accs, 1);
    cyc(0, 0, 0);

    // T2: three tiles of k_len=2
    run_job(2, 3, -1, 0, lat, accs, act);
    chk("t2_latency", lat, 49);
    chk("t2_accs", accs, 3);
    chk("t2_active", act, 48);
    cyc(0, 0, 0);

    // T3: k_len=8, 3-cycle stall at k_idx=3
    run_job(8, 1, 3, 3, lat, accs, act);
    chk("t3_latency", lat, 26);
    cyc(0, 0, 0);

    // T4: rejected configurations
    cnt = 0;
    k_len = 0;  num_tiles = 1; cyc(1, 0, 0); cyc(0, 0, 0); if (obs_cfg) cnt++;
    k_len = 17; num_tiles = 1; cyc(1, 0, 0); cyc(0, 0, 0); if (obs_cfg) cnt++;
    k_len = 4;  num_tiles = 0; cyc(1, 0, 0); cyc(0, 0, 0); if (obs_cfg) cnt++;
    chk("t4_cfg_pulses", cnt, 3);
    chk("t4_busy", o_busy, 0);

    // T5: abort during STORE of tile 1 of 3
    k_len = 2; num_tiles = 3;
    cyc(1, 0, 0);
    for (int c = 0; c < 200 && !(o_global_state == 3'd4 && o_tile_idx == 1); c++) cyc(0, 0, 0);
    chk("t5_reach_store", o_global_state == 3'd4 && o_tile_idx == 1, 1);
    cyc(0, 1, 0);
    chk("t5_idle", o_global_state, 0);
    chk("t5_tile", o_tile_idx, 0);
    repeat (3) cyc(0, 0, 0);

    // Asynchronous reset in the middle of MAC
    k_len = 8; num_tiles = 1;
    cyc(1, 0, 0);
    for (int c = 0; c < 50 && !(o_global_state == 3'd2 && o_k_idx == 2); c++) cyc(0, 0, 0);
    chk("rst_reach_mac", o_global_state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_state", o_global_state, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_mac_en", o_mac_en, 0);
    chk("mrst_k_idx", o_k_idx, 0);
    q.delete(); m_cfgerr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // T6: start held high; back-to-back jobs one IDLE cycle apart
    k_len = 2; num_tiles = 1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1, 0, 0);
      if (obs_done) cnt++;
    end
    chk("t6_dones", cnt, 2);
    for (int c = 0; c < 100 && o_busy; c++) cyc(0, 0, 0);

    // Random traffic: starts, stalls, aborts and config changes while busy
    for (int c = 0; c < 3000; c++) begin
      k_len     = KW'($urandom_range(0, 17));
      num_tiles = TILE_W'($urandom_range(0, 3));
      cyc(($urandom % 6) == 0, ($urandom % 80) == 0, ($urandom % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
